// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver, LSB first, one start and one stop bit.
// Define UART_RX_PARITY_EN to insert an even parity bit between data and stop.
module uart_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } stateType;

  stateType               state;
  stateType               stateNext;
  logic                   rxMeta;
  logic                   rxs;
  logic [CW-1:0]          baudCnt;
  logic [CW-1:0]          baudCntNext;
  logic [BW-1:0]          bitCnt;
  logic [BW-1:0]          bitCntNext;
  logic [DATA_BITS-1:0]   shiftReg;
  logic [DATA_BITS-1:0]   shiftRegNext;
  logic [DATA_BITS-1:0]   dataNext;
  logic                   validNext;
  logic                   frameErrNext;
`ifdef UART_RX_PARITY_EN
  logic                   parityBad;
  logic                   parityBadNext;
  logic                   parityErrNext;
`endif

  assign busy = (state != IDLE);

  // Two-flop synchronizer; idles high so reset never fakes a start bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rxMeta <= 1'b1;
      rxs    <= 1'b1;
    end else begin
      rxMeta <= rx;
      rxs    <= rxMeta;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      baudCnt   <= '0;
      bitCnt    <= '0;
      shiftReg  <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parityBad  <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      state     <= stateNext;
      baudCnt   <= baudCntNext;
      bitCnt    <= bitCntNext;
      shiftReg  <= shiftRegNext;
      data      <= dataNext;
      valid     <= validNext;
      frame_err <= frameErrNext;
`ifdef UART_RX_PARITY_EN
      parityBad  <= parityBadNext;
      parity_err <= parityErrNext;
`endif
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  // Each sample point is where baudCnt wraps; the counter restarts on every sample.
  always_comb begin
    stateNext    = state;
    baudCntNext  = baudCnt;
    bitCntNext   = bitCnt;
    shiftRegNext = shiftReg;
    dataNext     = data;
    validNext    = 1'b0;
    frameErrNext = 1'b0;
`ifdef UART_RX_PARITY_EN
    parityBadNext = parityBad;
    parityErrNext = 1'b0;
`endif

    case (state)
      IDLE: begin
        baudCntNext = '0;
        bitCntNext  = '0;
        if (!rxs) begin
          stateNext = START;
        end
      end

      START: begin
        if (baudCnt == HALF_LAST) begin
          baudCntNext = '0;
          stateNext   = rxs ? IDLE : DATA;
        end else begin
          baudCntNext = baudCnt + CW'(1);
        end
      end

      DATA: begin
        if (baudCnt == BIT_LAST) begin
          baudCntNext  = '0;
          shiftRegNext = {rxs, shiftReg[DATA_BITS-1:1]};
          bitCntNext   = bitCnt + BW'(1);
          if (bitCnt == DATA_LAST) begin
`ifdef UART_RX_PARITY_EN
            stateNext = PARITY;
`else
            stateNext = STOP;
`endif
          end
        end else begin
          baudCntNext = baudCnt + CW'(1);
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (baudCnt == BIT_LAST) begin
          baudCntNext   = '0;
          parityBadNext = (rxs != ^shiftReg);
          stateNext     = STOP;
        end else begin
          baudCntNext = baudCnt + CW'(1);
        end
      end
`endif

      // Leaving STOP at mid-bit lets a start bit right after the stop bit be seen.
      STOP: begin
        if (baudCnt == BIT_LAST) begin
          baudCntNext = '0;
          if (rxs) begin
            stateNext = IDLE;
`ifdef UART_RX_PARITY_EN
            if (parityBad) begin
              parityErrNext = 1'b1;
            end else begin
              validNext = 1'b1;
              dataNext  = shiftReg;
            end
`else
            validNext = 1'b1;
            dataNext  = shiftReg;
`endif
          end else begin
            stateNext    = WAIT_HIGH;
            frameErrNext = 1'b1;
          end
        end else begin
          baudCntNext = baudCnt + CW'(1);
        end
      end

      WAIT_HIGH: begin
        if (rxs) begin
          stateNext = IDLE;
        end
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at 16 clocks per bit, 8 data bits.
// Build with UART_RX_PARITY_EN defined to also exercise the parity frames.
module tb_uart_rx;

  localparam int CPB = 16;
  localparam logic [2:0] K_VALID  = 3'b100;
  localparam logic [2:0] K_FRAME  = 3'b010;
  localparam logic [2:0] K_PARITY = 3'b001;

  typedef struct {
    logic [2:0] kind;
    logic [7:0] data;
  } expType;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  expType     expQ[$];
  int         validTimes[$];
  int         compared;
  int         failed;
  int         cycle;
  int         busyLowCount;
  int         stableViol;
  logic       busyWatch;
  logic       inReset;
  logic [7:0] prevData;
`ifdef UART_RX_PARITY_EN
  logic       flipParity;
`endif

  uart_rx #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .data(data),
    .valid(valid),
    .frame_err(frame_err),
    .parity_err(parity_err),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: run did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every output pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    logic [2:0] kind;
    expType     e;
    kind = {valid, frame_err, parity_err};
    if (kind != 3'b000) begin
      if (valid) validTimes.push_back(cycle);
      if (expQ.size() == 0) begin
        checkOutput("unexpected pulse", {29'd0, kind}, 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("pulse kind", {29'd0, kind}, {29'd0, e.kind});
        checkOutput("pulse data", {24'd0, data}, {24'd0, e.data});
      end
    end
    if (busyWatch && !busy) busyLowCount++;
    if (!inReset && !valid && data !== prevData) stableViol++;
    prevData = data;
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sendFrame(input logic [7:0] d, input logic stopVal);
    rx = 1'b0;
    waitCycles(4);
    busyWatch = 1'b1;
    waitCycles(CPB - 4);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      waitCycles(CPB);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ flipParity;
    waitCycles(CPB);
`endif
    rx = stopVal;
    waitCycles(4);
    busyWatch = 1'b0;
    waitCycles(CPB - 4);
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic stopVal,
                               input logic [2:0] expKind, input logic [7:0] expData);
    expType e;
    e.kind = expKind;
    e.data = expData;
    expQ.push_back(e);
    sendFrame(d, stopVal);
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 200 && expQ.size() > 0; i++) waitCycles(1);
    if (expQ.size() != 0) begin
      checkOutput("scoreboard drain timeout", expQ.size(), 32'd0);
      expQ.delete();
    end
  endtask

  initial begin
    compared     = 0;
    failed       = 0;
    busyLowCount = 0;
    stableViol   = 0;
    busyWatch    = 1'b0;
    inReset      = 1'b1;
    prevData     = '0;
`ifdef UART_RX_PARITY_EN
    flipParity   = 1'b0;
`endif
    rst = 1'b0;
    rx  = 1'b1;
    waitCycles(3);
    checkOutput("reset data", {24'd0, data}, 32'd0);
    checkOutput("reset valid", {31'd0, valid}, 32'd0);
    checkOutput("reset frame_err", {31'd0, frame_err}, 32'd0);
    checkOutput("reset parity_err", {31'd0, parity_err}, 32'd0);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;
    waitCycles(2);
    inReset = 1'b0;
    waitCycles(2 * CPB);

    $display("[TB] frame 0xA5");
    applyStimulus(8'hA5, 1'b1, K_VALID, 8'hA5);
    waitDrain();
    checkOutput("data after 0xA5", {24'd0, data}, 32'hA5);
    waitCycles(2 * CPB);

    $display("[TB] start glitch");
    rx = 1'b0;
    waitCycles(4);
    rx = 1'b1;
    checkOutput("glitch busy raised", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 8 && busy; i++) waitCycles(1);
    checkOutput("glitch busy cleared", {31'd0, busy}, 32'd0);
    waitCycles(2 * CPB);

    $display("[TB] bad stop bit then break");
    applyStimulus(8'h3C, 1'b0, K_FRAME, 8'hA5);
    waitCycles(40 * CPB);
    checkOutput("break holds busy", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    waitCycles(4);
    checkOutput("idle after break", {31'd0, busy}, 32'd0);
    checkOutput("data kept after frame_err", {24'd0, data}, 32'hA5);
    waitCycles(2 * CPB);

    $display("[TB] back-to-back 0x00, 0xFF");
    validTimes.delete();
    applyStimulus(8'h00, 1'b1, K_VALID, 8'h00);
    applyStimulus(8'hFF, 1'b1, K_VALID, 8'hFF);
    waitDrain();
    checkOutput("b2b valid count", validTimes.size(), 32'd2);
    if (validTimes.size() == 2)
      checkOutput("b2b valid spacing", validTimes[1] - validTimes[0], 32'd160);
    checkOutput("data after b2b", {24'd0, data}, 32'hFF);
    waitCycles(2 * CPB);

    $display("[TB] reset inside data bit 4");
    rx = 1'b0;
    waitCycles(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = (i % 2 == 0) ? 1'b0 : 1'b1;
      waitCycles(CPB);
    end
    rx = 1'b1;
    waitCycles(CPB / 2);
    inReset = 1'b1;
    rst = 1'b0;
    waitCycles(1);
    rst = 1'b1;
    checkOutput("abort data", {24'd0, data}, 32'd0);
    checkOutput("abort valid", {31'd0, valid}, 32'd0);
    checkOutput("abort frame_err", {31'd0, frame_err}, 32'd0);
    checkOutput("abort parity_err", {31'd0, parity_err}, 32'd0);
    checkOutput("abort busy", {31'd0, busy}, 32'd0);
    waitCycles(4 * CPB);
    inReset = 1'b0;
    applyStimulus(8'h5A, 1'b1, K_VALID, 8'h5A);
    waitDrain();
    checkOutput("data after 0x5A", {24'd0, data}, 32'h5A);
    waitCycles(2 * CPB);

`ifdef UART_RX_PARITY_EN
    $display("[TB] parity frames");
    flipParity = 1'b1;
    applyStimulus(8'h07, 1'b1, K_PARITY, 8'h5A);
    waitDrain();
    checkOutput("data after parity_err", {24'd0, data}, 32'h5A);
    flipParity = 1'b0;
    waitCycles(2 * CPB);
    applyStimulus(8'h07, 1'b1, K_VALID, 8'h07);
    waitDrain();
    checkOutput("data after good parity", {24'd0, data}, 32'h07);
    waitCycles(2 * CPB);
`endif

    waitCycles(4);
    checkOutput("leftover expectations", expQ.size(), 32'd0);
    checkOutput("busy low inside frame", busyLowCount, 32'd0);
    checkOutput("data changed without valid", stableViol, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 868, giving clk cycles per serial bit; legal minimum 4.
REQ-002 SHALL provide parameter DATA_BITS, default 8, giving data bits per frame; legal range 5..8.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port data  output  DATA_BITS  last correctly received word.
REQ-007 SHALL have port valid  output  1  one-cycle pulse marking a new word on data.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-009 SHALL have port parity_err  output  1  one-cycle pulse on a parity mismatch (tied 0 when parity is compiled out).
REQ-010 SHALL have port busy  output  1  high whenever a frame is in progress.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer (flops reset to 1); all decisions use the synchronized value rxs.
REQ-012 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH; busy = (state != IDLE).
REQ-013 IDLE: rxs == 0 -> START, bit counter cleared.
REQ-014 START: after CLKS_PER_BIT/2 cycles, sample rxs; 0 -> DATA; 1 -> IDLE (glitch, no output pulse).
REQ-015 DATA: sample rxs every CLKS_PER_BIT cycles (mid-bit); shift LSB first; after DATA_BITS samples -> PARITY if enabled, else STOP.
REQ-016 PARITY: sample one bit CLKS_PER_BIT cycles after the last data sample; compare with even parity over the data bits.
REQ-017 STOP: sample CLKS_PER_BIT cycles after the previous sample; 1 -> IDLE; 0 -> WAIT_HIGH.
REQ-018 On a good stop bit with no parity error: data updates and valid pulses on the cycle after the stop sample.
REQ-019 On a bad stop bit: frame_err pulses on the cycle after the stop sample; data holds its previous value; valid stays low.
REQ-020 On a parity mismatch with a good stop bit: parity_err pulses on the cycle after the stop sample; data unchanged; valid low.
REQ-021 A bad stop bit takes priority: frame_err only, parity_err suppressed.
REQ-022 WAIT_HIGH: remain until rxs == 1, then IDLE; a held-low line (break) yields exactly one frame_err.
REQ-023 Return to IDLE coincides with the stop sample, so a start bit immediately following the stop bit SHALL be accepted (back-to-back frames).
REQ-024 data SHALL remain stable between valid pulses; valid, frame_err and parity_err are never high for more than 1 cycle.
REQ-025 The baud counter SHALL be sized ceil(log2(CLKS_PER_BIT)) bits and wrap to 0 at CLKS_PER_BIT-1.

Reset
REQ-026 While rst == 0 at a clk edge: state = IDLE; counters = 0; synchronizer = 1; data = 0; valid = frame_err = parity_err = busy = 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no output pulse; the next full frame after release SHALL be received correctly.

Configuration
REQ-028 Macro UART_RX_PARITY_EN SHALL control the parity feature.
REQ-029 Defined: frame = start + DATA_BITS + even parity + stop; the PARITY state is active and parity_err is driven per REQ-020.
REQ-030 Undefined: frame = start + DATA_BITS + stop; PARITY is unreachable; parity_err = 0 constantly; the port list is unchanged.

Verification (CLKS_PER_BIT = 16, DATA_BITS = 8)
REQ-031 Frame 0xA5, parity off -> one valid pulse with data = 0xA5, busy high throughout, frame_err = 0.
REQ-032 rx low for 4 cycles then high -> no valid/frame_err; busy returns to 0 within 8 cycles of the start.
REQ-033 Frame 0x3C followed by a 0 stop bit, line held low 40 bit times -> exactly one frame_err; data keeps its previous value; IDLE after rx rises.
REQ-034 Back-to-back frames 0x00 then 0xFF with no idle gap -> two valid pulses, data 0x00 then 0xFF, 160 cycles apart.
REQ-035 rst low for 1 cycle in the middle of data bit 4 -> all outputs 0; the following frame 0x5A is received with valid.
REQ-036 UART_RX_PARITY_EN defined, frame 0x07 with parity bit 0 (wrong) -> parity_err pulse, no valid; with parity bit 1 -> valid, data = 0x07.
